// File: rtl/csa_pkg.sv
// Shared definitions for the nibble-serial carry-select adder controller.
package csa_pkg;

  // Width of the single arithmetic slice that is time-multiplexed.
  localparam int SLICE_W = 4;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the slice index counter (at least one bit).
  function automatic int idx_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/csa_nibble.sv
// Purely combinational 4-bit carry-select slice: two ripple chains are
// evaluated in parallel, one assuming carry-in 0 and one assuming carry-in 1,
// and the real carry-in only picks the finished result.
module csa_nibble
  import csa_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
);

  logic [SLICE_W-1:0] w_s0;
  logic [SLICE_W-1:0] w_s1;
  logic [SLICE_W:0]   w_c0;
  logic [SLICE_W:0]   w_c1;

  // Precompute both ripple chains.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    w_s0    = '0;
    w_s1    = '0;
    w_c0    = '0;
    w_c1    = '0;
    w_c0[0] = 1'b0;
    w_c1[0] = 1'b1;
    for (int i = 0; i < SLICE_W; i++) begin
      w_s0[i]   = a[i] ^ b[i] ^ w_c0[i];
      w_c0[i+1] = (a[i] & b[i]) | (w_c0[i] & (a[i] ^ b[i]));
      w_s1[i]   = a[i] ^ b[i] ^ w_c1[i];
      w_c1[i+1] = (a[i] & b[i]) | (w_c1[i] & (a[i] ^ b[i]));
    end
  end

  // Late-arriving carry selects between the two precomputed results.
  assign s  = ci ? w_s1 : w_s0;
  assign co = ci ? w_c1[SLICE_W] : w_c0[SLICE_W];

endmodule

// File: rtl/csa_seq_ctrl.sv
// Area-reduced wide adder: one carry-select nibble slice is reused once per
// clock, LSB nibble first, with the running carry held in a register.
// Operands arrive on a valid/ready handshake; the result leaves on another.
module csa_seq_ctrl
  import csa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = idx_width(NSLICE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  // The operand must split into whole nibbles.
  generate
    if (WIDTH < SLICE_W || (WIDTH % SLICE_W) != 0) begin : g_bad_width
      $error("csa_seq_ctrl: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  state_t             r_state;
  state_t             w_state_next;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;

  int                 w_ofs;
  logic [SLICE_W-1:0] w_a_nib;
  logic [SLICE_W-1:0] w_b_nib;
  logic [SLICE_W-1:0] w_nib_s;
  logic               w_nib_co;
  logic               w_last;

  // Bit offset of the nibble currently being processed.
  assign w_ofs   = int'(r_idx) * SLICE_W;
  assign w_a_nib = r_a[w_ofs +: SLICE_W];
  assign w_b_nib = r_b[w_ofs +: SLICE_W];
  assign w_last  = (r_idx == LAST_IDX);

  csa_nibble u_nibble (
    .a  (w_a_nib),
    .b  (w_b_nib),
    .ci (r_carry),
    .s  (w_nib_s),
    .co (w_nib_co)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state always uses non-blocking assignment so every register samples pre-edge values.
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode: accept in IDLE, step through nibbles in RUN,
  // hold the result in DONE until the consumer takes it.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_next = RUN;
      RUN:     if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state alone.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      IDLE: in_ready = 1'b1;
      RUN:  busy     = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Datapath: capture operands, then write one sum nibble per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: operand and result registers are plain flops, so resetting them is cheap and gives a defined sum after reset.
    if (!rst_n) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_sum   <= '0;
          end
        end
        RUN: begin
          r_sum[w_ofs +: SLICE_W] <= w_nib_s;
          r_carry                 <= w_nib_co;
          if (w_last) begin
            r_idx  <= '0;
            r_cout <= w_nib_co;
          end else begin
            r_idx  <= r_idx + 1'b1;
          end
        end
        default: begin
          // DONE: result held until the next capture clears it.
        end
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_csa_seq_ctrl.sv
// Self-checking bench for csa_seq_ctrl: a 16-bit and a 4-bit instance,
// expected results come from an integer model through scoreboard queues.
module tb_csa_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 16-bit instance signals
  logic        iv16 = 1'b0, or16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        ir16, ov16, cout16, busy16;
  logic [15:0] sum16;

  // 4-bit instance signals
  logic        iv4 = 1'b0, or4 = 1'b0, cin4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        ir4, ov4, cout4, busy4;
  logic [3:0]  sum4;

  csa_seq_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .cin(cin16), .out_valid(ov16), .out_ready(or16),
    .sum(sum16), .cout(cout16), .busy(busy16)
  );

  csa_seq_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(ov4), .out_ready(or4),
    .sum(sum4), .cout(cout4), .busy(busy4)
  );

  typedef struct packed { logic [15:0] sum; logic cout; } exp16_t;
  typedef struct packed { logic [3:0]  sum; logic cout; } exp4_t;

  exp16_t q16[$];
  exp4_t  q4[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic exp16_t model16(input logic [15:0] a, input logic [15:0] b, input logic ci);
    logic [16:0] t;
    exp16_t e;
    t = {1'b0, a} + {1'b0, b} + {16'd0, ci};
    e.sum  = t[15:0];
    e.cout = t[16];
    return e;
  endfunction

  function automatic exp4_t model4(input logic [3:0] a, input logic [3:0] b, input logic ci);
    logic [4:0] t;
    exp4_t e;
    t = {1'b0, a} + {1'b0, b} + {4'd0, ci};
    e.sum  = t[3:0];
    e.cout = t[4];
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one operation to the 16-bit instance and record its expectation.
  task automatic accept16(input logic [15:0] a, input logic [15:0] b, input logic ci);
    int n = 0;
    while (ir16 !== 1'b1 && n < 50) begin step(); n++; end
    if (n >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL accept16_timeout: in_ready=%b after 50 cycles, wanted 1", ir16);
    end
    a16 = a; b16 = b; cin16 = ci; iv16 = 1'b1;
    step();
    iv16 = 1'b0;
    q16.push_back(model16(a, b, ci));
  endtask

  // Wait for the 16-bit result, optionally stall, then compare and retire it.
  task automatic wait_result16(input int stall, output int lat, output int busy_cnt);
    exp16_t e;
    int j;
    lat = -1; busy_cnt = 0;
    or16 = (stall == 0);
    for (j = 0; j < 40; j++) begin
      if (busy16) busy_cnt++;
      if (ov16) break;
      n_checks++;
      if (ir16 !== 1'b0) begin
        n_fail++;
        $display("FAIL in_ready_while_busy: got %b wanted 0", ir16);
      end
      step();
    end
    if (ov16 !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL result_timeout: out_valid=%b after 40 cycles, wanted 1", ov16);
      or16 = 1'b0;
      return;
    end
    lat = j;
    if (q16.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard16_empty: result seen with no expectation");
      return;
    end
    e = q16[0];
    for (int s = 0; s < stall; s++) begin
      n_checks++;
      if (ov16 !== 1'b1 || sum16 !== e.sum || cout16 !== e.cout) begin
        n_fail++;
        $display("FAIL hold_stable: ov=%b sum=%h cout=%b wanted ov=1 sum=%h cout=%b",
                 ov16, sum16, cout16, e.sum, e.cout);
      end
      step();
    end
    or16 = 1'b1;
    e = q16.pop_front();
    n_checks++;
    if (sum16 !== e.sum) begin
      n_fail++;
      $display("FAIL sum16: got %h wanted %h", sum16, e.sum);
    end
    n_checks++;
    if (cout16 !== e.cout) begin
      n_fail++;
      $display("FAIL cout16: got %b wanted %b", cout16, e.cout);
    end
    step();
    or16 = 1'b0;
    n_checks++;
    if (ov16 !== 1'b0 || ir16 !== 1'b1) begin
      n_fail++;
      $display("FAIL handshake_exit: ov=%b ir=%b wanted ov=0 ir=1", ov16, ir16);
    end
  endtask

  // One complete 4-bit operation with out_ready held high.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic ci, output int lat);
    exp4_t e;
    int j;
    int n = 0;
    lat = -1;
    while (ir4 !== 1'b1 && n < 20) begin step(); n++; end
    a4 = a; b4 = b; cin4 = ci; iv4 = 1'b1; or4 = 1'b1;
    step();
    iv4 = 1'b0;
    q4.push_back(model4(a, b, ci));
    for (j = 0; j < 20; j++) begin
      if (ov4) break;
      step();
    end
    if (ov4 !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL result4_timeout: out_valid=%b after 20 cycles, wanted 1", ov4);
      q4.delete();
      return;
    end
    lat = j;
    e = q4.pop_front();
    n_checks++;
    if (sum4 !== e.sum || cout4 !== e.cout) begin
      n_fail++;
      $display("FAIL result4: a=%h b=%h ci=%b got sum=%h cout=%b wanted sum=%h cout=%b",
               a, b, ci, sum4, cout4, e.sum, e.cout);
    end
    step();
    n_checks++;
    if (ov4 !== 1'b0) begin
      n_fail++;
      $display("FAIL handshake4_exit: out_valid=%b wanted 0", ov4);
    end
  endtask

  task automatic test_reset();
    int lat, bc;
    a16 = 16'h0F0F; b16 = 16'h0101; cin16 = 1'b1; iv16 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (ir16 !== 1'b1 || ov16 !== 1'b0 || busy16 !== 1'b0 || sum16 !== 16'h0 || cout16 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset16: ir=%b ov=%b busy=%b sum=%h cout=%b wanted 1 0 0 0000 0",
               ir16, ov16, busy16, sum16, cout16);
    end
    n_checks++;
    if (ir4 !== 1'b1 || ov4 !== 1'b0 || busy4 !== 1'b0 || sum4 !== 4'h0 || cout4 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset4: ir=%b ov=%b busy=%b sum=%h cout=%b wanted 1 0 0 0 0",
               ir4, ov4, busy4, sum4, cout4);
    end
    // Release reset with in_valid already high: capture on the next edge.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (busy16 !== 1'b0) begin
      n_fail++;
      $display("FAIL release_no_capture: busy=%b wanted 0", busy16);
    end
    step();
    iv16 = 1'b0;
    q16.push_back(model16(16'h0F0F, 16'h0101, 1'b1));
    n_checks++;
    if (busy16 !== 1'b1) begin
      n_fail++;
      $display("FAIL release_first_capture: busy=%b wanted 1", busy16);
    end
    wait_result16(0, lat, bc);
  endtask

  task automatic test_basic();
    int lat, bc;
    accept16(16'h1234, 16'h4321, 1'b0);
    wait_result16(0, lat, bc);
    n_checks++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d wanted 4", lat);
    end
    n_checks++;
    if (bc !== 5) begin
      n_fail++;
      $display("FAIL basic_busy_cycles: got %0d wanted 5", bc);
    end
  endtask

  task automatic test_carry_chain();
    int lat, bc;
    accept16(16'hFFFF, 16'h0001, 1'b0);
    wait_result16(0, lat, bc);
    accept16(16'hFFFF, 16'h0000, 1'b1);
    wait_result16(0, lat, bc);
    n_checks++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL carry_latency: got %0d wanted 4", lat);
    end
  endtask

  task automatic test_back_to_back();
    exp16_t e;
    int caps = 0;
    int res = 0;
    or16 = 1'b1;
    a16 = 16'h0001; b16 = 16'h0001; cin16 = 1'b0; iv16 = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      n_checks++;
      if (ir16 !== (busy16 ? 1'b0 : 1'b1)) begin
        n_fail++;
        $display("FAIL b2b_in_ready: ir=%b busy=%b", ir16, busy16);
      end
      if (ov16 && or16) begin
        if (q16.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL b2b_scoreboard_empty: result with no expectation");
        end else begin
          e = q16.pop_front();
          n_checks++;
          if (sum16 !== e.sum || cout16 !== e.cout) begin
            n_fail++;
            $display("FAIL b2b_result%0d: got sum=%h cout=%b wanted sum=%h cout=%b",
                     res, sum16, cout16, e.sum, e.cout);
          end
        end
        res++;
      end
      if (iv16 && ir16) begin
        if (caps == 1) begin
          n_checks++;
          if (res != 1) begin
            n_fail++;
            $display("FAIL b2b_second_capture: results retired %0d wanted 1", res);
          end
        end
        q16.push_back(model16(a16, b16, cin16));
        caps++;
      end
      step();
      if (caps == 1) begin a16 = 16'hAAAA; b16 = 16'h5555; end
      if (caps == 2) iv16 = 1'b0;
      if (caps == 2 && res == 2) break;
    end
    iv16 = 1'b0; or16 = 1'b0;
    n_checks++;
    if (caps != 2 || res != 2) begin
      n_fail++;
      $display("FAIL b2b_complete: captures=%0d results=%0d wanted 2 and 2", caps, res);
    end
  endtask

  task automatic test_backpressure();
    int lat, bc;
    accept16(16'h8000, 16'h8000, 1'b0);
    wait_result16(6, lat, bc);
    n_checks++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d wanted 4", lat);
    end
  endtask

  task automatic test_reset_mid_run();
    int lat, bc;
    accept16(16'h1111, 16'h2222, 1'b0);
    q16.delete();
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ov16 !== 1'b0 || sum16 !== 16'h0 || cout16 !== 1'b0 || ir16 !== 1'b1 || busy16 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_run_reset: ov=%b sum=%h cout=%b ir=%b busy=%b wanted 0 0000 0 1 0",
               ov16, sum16, cout16, ir16, busy16);
    end
    #1;
    rst_n = 1'b1;
    accept16(16'h00FF, 16'h0001, 1'b0);
    wait_result16(0, lat, bc);
    n_checks++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL post_reset_latency: got %0d wanted 4", lat);
    end
  endtask

  task automatic test_width4();
    int lat;
    op4(4'hF, 4'h1, 1'b1, lat);
    n_checks++;
    if (lat !== 1) begin
      n_fail++;
      $display("FAIL w4_latency: got %0d wanted 1", lat);
    end
    for (int i = 0; i < 512; i++) begin
      op4(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_chain();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    test_width4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
